// File: rtl/delay_line_tap.sv
// Programmable delay line: a DEPTH-stage {valid,data} shift chain with a registered tap select.
// Delay changes and flushes clear the chain and hold 'settling' until the selected tap refills.
module delay_line_tap #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [$clog2(DEPTH+1)-1:0] delay_sel,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       settling
);

  localparam int SW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    eff;
  logic             tap_vld;
  logic [WIDTH-1:0] tap_dat;

  // Clamp the requested delay into the legal range 1..DEPTH
  always_comb begin
    if (delay_sel == '0) begin
      eff = SW'(1);
    end else if (delay_sel > SW'(DEPTH)) begin
      eff = SW'(DEPTH);
    end else begin
      eff = delay_sel;
    end
  end

  // Next-state: flush and delay change both restart the chain, otherwise shift when enabled
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (flush || (eff != sel_q)) begin
      vld_d = '0;
      sel_d = eff;
      cnt_d = eff;
    end else if (en) begin
      vld_d    = {vld_q[DEPTH-2:0], in_valid};
      dat_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        dat_d[i] = dat_q[i-1];
      end
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - SW'(1);
    end else begin
      vld_d = vld_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
      sel_q <= SW'(1);
      cnt_q <= SW'(1);
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  // Tap mux over registered stages; data is masked whenever the tapped stage is empty
  always_comb begin
    tap_vld = 1'b0;
    tap_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tap_vld = tap_vld | ((sel_q == SW'(i + 1)) & vld_q[i]);
      tap_dat = tap_dat | ({WIDTH{(sel_q == SW'(i + 1)) & vld_q[i]}} & dat_q[i]);
    end
  end

  assign out_valid = tap_vld;
  assign out_data  = tap_dat;
  assign settling  = (cnt_q != '0);

endmodule

// File: doc/delay_line_tap.md
DELAY_LINE_TAP -- requirements
Module: delay_line_tap

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, maximum delay in clock cycles (>=2); number of internal stages.
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous assert, active-high; released synchronously by the system.
REQ-005 Port en  input  1  shift enable; 0 = stall, all state held.
REQ-006 Port flush  input  1  synchronous clear of in-flight samples.
REQ-007 Port delay_sel  input  $clog2(DEPTH+1)  requested delay in cycles.
REQ-008 Port in_valid  input  1  in_data carries a sample this cycle.
REQ-009 Port in_data  input  WIDTH  input sample.
REQ-010 Port out_valid  output  1  out_data carries a delayed sample.
REQ-011 Port out_data  output  WIDTH  delayed sample; all-zero when out_valid=0.
REQ-012 Port settling  output  1  delay changed or flushed, tap not yet refilled.

Function
REQ-013 DEPTH stages, each {valid, data}; on enabled edge stage[0] <= {in_valid, in_data}, stage[i] <= stage[i-1].
REQ-014 Effective delay eff = 1 if delay_sel=0; DEPTH if delay_sel>DEPTH; else delay_sel.
REQ-015 Registered tap sel_q holds active delay; out_valid/out_data = stage[sel_q-1], driven from registers only (no combinational in->out path).
REQ-016 Latency: sample captured at enabled edge N appears at out after the edge ending the sel_q-th enabled cycle, i.e. visible exactly sel_q enabled edges after capture; one cycle wide per enabled cycle.
REQ-017 en=0: no stage, sel_q or counter change; outputs constant; flush and delay change are still acted on (REQ-018/019).
REQ-018 Delay change: at any edge where eff != sel_q: sel_q <= eff, all stage valids cleared, stage[0] not loaded (input dropped), settle counter <= eff.
REQ-019 flush=1 at an edge: all stage valids cleared, input dropped, settle counter <= eff, sel_q <= eff.
REQ-020 Priority per edge: rst > flush > delay change > enabled shift.
REQ-021 Settle counter width $clog2(DEPTH+1); decrements by 1 on each enabled edge not covered by REQ-018/019; saturates at 0.
REQ-022 settling = (counter != 0); stage valids remain low while settling=1 for every tap position <= sel_q, so no stale or duplicated sample is ever output.
REQ-023 Stage data of invalid stages is don't-care internally; out_data masked to 0 when out_valid=0.
REQ-024 No wrap-around or overflow: stages are a pure shift chain; each accepted sample emerges exactly once unless removed by flush, delay change or rst.

Reset
REQ-025 rst=1 asynchronously: all stage valids 0, stage data 0, sel_q=1, counter=1, out_valid=0, out_data=0, settling=1.
REQ-026 After rst release the first edge with eff != 1 is treated as a delay change (REQ-018); otherwise counter reaches 0 after one enabled edge.
REQ-027 rst asserted mid-stream discards all in-flight samples; no sample captured before rst appears after release.

Verification
REQ-028 Reset: rst=1 at t=0, release after 2 clocks -> out_valid=0, out_data=0x00, settling=1 during and immediately after reset.
REQ-029 Fixed delay: WIDTH=8, DEPTH=16, delay_sel=2, en=1, single 0xA5 at edge N -> out_valid=1, out_data=0xA5 only in the cycle after edge N+1, 0x00 before and after.
REQ-030 Stall: delay_sel=4, 0x3C captured at edge N, en=0 for 3 cycles in flight -> 0x3C appears after 7 edges total, exactly once.
REQ-031 Delay change: stream 0x01,0x02,... at delay 4, change delay_sel to 8 -> out_valid=0 and settling=1 for exactly 8 enabled edges, then first sample captured after change emerges 8 edges after capture; no old sample output.
REQ-032 Clamp/flush: delay_sel=0 -> 1-cycle delay; delay_sel=31 -> 16-cycle delay; flush=1 with in_valid=1 -> that sample and all in-flight samples never appear, settling=1 for eff edges.
REQ-033 Async reset mid-operation: rst pulsed between edges with 5 samples in flight -> out_valid drops to 0 immediately, none of the 5 samples appears afterwards.
